// File: rtl/uart_rx_frame_fifo.sv
// UART x16 oversampled receiver feeding a show-ahead frame FIFO.
// Optional error counter output enabled by UART_RX_ERR_CNT_EN.
module uart_rx_frame_fifo #(
  parameter int OVS_DIV    = 27,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          frame_data,
  output logic [1:0]                    frame_err,
  output logic                          frame_valid,
  input  logic                          frame_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  input  logic                          clr_ovr
`ifdef UART_RX_ERR_CNT_EN
  ,
  output logic [7:0]                    err_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_BITS + 2;
  localparam int DW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("DATA_BITS out of range");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2, >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_PUSH
  } state_t;

  state_t               state_q;
  state_t               state_d;

  logic                 rx_s1;
  logic                 rx_s2;
  logic                 rx_prev;
  logic [1:0]           fill;
  logic                 armed;
  logic                 start_edge;

  logic [DW-1:0]        div_cnt;
  logic                 tick;
  logic [3:0]           tick_cnt;
  logic [3:0]           bit_cnt;
  logic                 mid_tick;
  logic                 bit_tick;
  logic                 last_bit;

  logic [DATA_BITS-1:0] shreg;
  logic                 par_err;
  logic                 fr_err;

  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [EW-1:0]        head;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 wr_en;
  logic                 drop;

  // Synchronise rx; arm edge detection only after a real high is seen
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      fill    <= 2'b00;
      armed   <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      fill    <= {fill[0], 1'b1};
      if (fill[1] && rx_s2)
        armed <= 1'b1;
    end
  end

  assign start_edge = armed & rx_prev & ~rx_s2;

  // Free-running oversample tick divider
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      div_cnt <= '0;
    else if (div_cnt == DW'(OVS_DIV - 1))
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 1'b1;
  end

  assign tick     = (div_cnt == DW'(OVS_DIV - 1));
  assign mid_tick = tick && (tick_cnt == 4'd7);
  assign bit_tick = tick && (tick_cnt == 4'd15);
  assign last_bit = (bit_cnt == 4'(DATA_BITS - 1));

  // Receiver state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Receiver next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_edge)
          state_d = S_START;
      end
      S_START: begin
        if (mid_tick)
          state_d = rx_s2 ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (bit_tick && last_bit)
          state_d = (PARITY != 0) ? S_PAR : S_STOP;
      end
      S_PAR: begin
        if (bit_tick)
          state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_tick)
          state_d = S_PUSH;
      end
      S_PUSH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Tick/bit counters, data shifter and error capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_err  <= 1'b0;
      fr_err   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
          par_err  <= 1'b0;
        end
        S_START: begin
          if (mid_tick)
            tick_cnt <= '0;
          else if (tick)
            tick_cnt <= tick_cnt + 4'd1;
        end
        S_DATA: begin
          if (tick)
            tick_cnt <= tick_cnt + 4'd1;
          if (bit_tick) begin
            shreg   <= {rx_s2, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        S_PAR: begin
          if (tick)
            tick_cnt <= tick_cnt + 4'd1;
          if (bit_tick) begin
            if (PARITY == 1)
              par_err <= ~(^{shreg, rx_s2});
            else
              par_err <= ^{shreg, rx_s2};
          end
        end
        S_STOP: begin
          if (tick)
            tick_cnt <= tick_cnt + 4'd1;
          if (bit_tick)
            fr_err <= ~rx_s2;
        end
        default: begin
        end
      endcase
    end
  end

  assign push  = (state_q == S_PUSH);
  assign full  = (fifo_count == CW'(FIFO_DEPTH));
  assign pop   = frame_valid & frame_ready;
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  // Frame FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= {par_err, fr_err, shreg};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)
        fifo_count <= fifo_count + 1'b1;
      else if (!wr_en && pop)
        fifo_count <= fifo_count - 1'b1;
    end
  end

  assign head        = mem[rd_ptr];
  assign frame_data  = head[DATA_BITS-1:0];
  assign frame_err   = head[EW-1:DATA_BITS];
  assign frame_valid = (fifo_count != '0);

  // Sticky overrun; a drop in the same cycle beats the clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      overrun <= 1'b0;
    else if (drop)
      overrun <= 1'b1;
    else if (clr_ovr)
      overrun <= 1'b0;
  end

`ifdef UART_RX_ERR_CNT_EN
  logic err_inc;

  assign err_inc = (wr_en & (par_err | fr_err)) | drop;

  // Saturating error counter; an increment beats the clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      err_cnt <= '0;
    else if (err_inc) begin
      if (err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end else if (clr_ovr)
      err_cnt <= '0;
  end
`endif

endmodule
